pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised program-counter generator for the five-stage pipeline fetch stage; successor to the single-width PC register. It selects the next fetch address by fixed priority: trap, EX-stage redirect, stall hold, return-address prediction, then sequential increment. It contains a circular return-address stack (RAS) so IF can predict returns without waiting for EX.

Parameters:
WIDTH, 32, address width in bits
RESET_PC, 0, fetch address held during and after reset
TRAP_PC, 32'h0000_0080, fetch address on trap
STEP, 4, sequential increment in bytes; power of two >= 1
RAS_DEPTH, 4, return-address stack entries; power of two >= 2

Ports:
CLK  input  1  clock, rising edge
Reset_n  input  1  asynchronous active-low reset
stall  input  1  hold curPC (load-use hazard)
trap  input  1  exception; redirect to TRAP_PC
redirect_valid  input  1  EX-stage branch or jump resolved taken
redirect_pc  input  WIDTH  branch or jump target
call  input  1  instruction at curPC is a call; push curPC+STEP
ret  input  1  instruction at curPC is a return; pop and predict
curPC  output  WIDTH  current fetch address (registered)
pc_valid  output  1  curPC is a fetchable address
misaligned  output  1  registered pulse: last accepted redirect_pc was unaligned
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_full  output  1  ras_count == RAS_DEPTH
ras_empty  output  1  ras_count == 0

Behaviour:
- Reset (Reset_n low, asynchronous): curPC=RESET_PC, pc_valid=0, misaligned=0, ras_count=0, top pointer=0. RAS entry contents are don't-care.
- First rising edge after release: pc_valid<=1; curPC stays RESET_PC. All other inputs are ignored on this edge. Normal operation starts on the next edge.
- Next-PC priority, evaluated each edge while pc_valid=1:
  1. trap: curPC<=TRAP_PC; RAS cleared (ras_count<=0). call and ret are ignored.
  2. redirect_valid: curPC<=redirect_pc with the low log2(STEP) bits forced to 0. misaligned<=1 if any of those bits were nonzero. RAS is unchanged; call and ret are ignored.
  3. stall: curPC held. call and ret are ignored. The RAS is not modified.
  4. ret with ras_empty=0: curPC<=top entry; pop.
  5. Otherwise: curPC<=curPC+STEP, modulo 2^WIDTH (wraps silently). This includes ret with ras_empty=1, which also performs no pop.
- misaligned is 0 on every edge that does not set it (one-cycle pulse).
- call push occurs only when no trap, redirect or stall is active. Push writes curPC+STEP (modulo 2^WIDTH).
- RAS is circular:
  - Push when ras_full: overwrite the oldest entry, advance the top pointer; ras_count stays RAS_DEPTH.
  - Push otherwise: ras_count+1.
  - Pop: top pointer decrements, wrapping modulo RAS_DEPTH; ras_count-1.
- call and ret on the same edge with ras_empty=0: curPC<=popped top entry, and curPC+STEP replaces that top entry in place; ras_count unchanged.
- call and ret on the same edge with ras_empty=1: sequential increment plus push.
- ras_full and ras_empty are combinational from ras_count.
- Reset asserted mid-operation: immediate return to reset values regardless of CLK.
- No combinational path from any input to curPC.

Test Plan:
- Reset release, no stimulus -> curPC 0 with pc_valid 0, then 0 with pc_valid 1, then 4, 8, 12 on successive edges.
- redirect_valid=1 with redirect_pc=0x106 -> curPC=0x104; misaligned=1 for exactly one cycle. Next edge: curPC=0x108.
- Calls at curPC 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH 4) -> ras_full after the 4th call, ras_count stays 4. Then five rets pop 0x54, 0x44, 0x34, 0x24; the 5th ret is on empty and gives sequential +4.
- stall=1 asserted together with call and ret for 3 cycles -> curPC constant, ras_count unchanged. When stall drops, the pending ret pops as normal.
- trap, redirect_valid and ret asserted on the same edge with ras_count=2 -> curPC=0x80, ras_count=0, misaligned=0.
- curPC=0xFFFFFFFC with no control inputs -> next curPC=0x00000000. Reset_n pulsed low between edges -> curPC=0 and pc_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: trap / redirect / stall / RAS-predicted
// return / sequential priority, with a circular return-address stack.
module pc_gen #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] TRAP_PC  = WIDTH'(32'h0000_0080),
    parameter int unsigned     STEP      = 4,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic                             CLK,
    input  logic                             Reset_n,
    input  logic                             stall,
    input  logic                             trap,
    input  logic                             redirect_valid,
    input  logic [WIDTH-1:0]                 redirect_pc,
    input  logic                             call,
    input  logic                             ret,
    output logic [WIDTH-1:0]                 curPC,
    output logic                             pc_valid,
    output logic                             misaligned,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_full,
    output logic                             ras_empty
);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    top, top_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] pc_next, seq_pc;
    logic             mis_next;
    logic             ras_we;
    logic [PW-1:0]    ras_widx;
    logic             pop;

    assign ras_full  = (ras_count == DEPTH_C);
    assign ras_empty = (ras_count == '0);
    assign seq_pc    = curPC + STEP_W;

    always_comb begin
        pc_next    = seq_pc;
        count_next = ras_count;
        top_next   = top;
        mis_next   = 1'b0;
        ras_we     = 1'b0;
        ras_widx   = top;
        pop        = ret && !ras_empty;
        if (!pc_valid) begin
            pc_next = curPC;
        end else if (trap) begin
            pc_next    = TRAP_PC;
            count_next = '0;
        end else if (redirect_valid) begin
            pc_next  = redirect_pc & ~LOW_MASK;
            mis_next = |(redirect_pc & LOW_MASK);
        end else if (stall) begin
            pc_next = curPC;
        end else begin
            if (pop)
                pc_next = ras_mem[top];
            // call+ret on a non-empty stack swaps the top entry in place
            if (call && pop) begin
                ras_we = 1'b1;
            end else if (call) begin
                ras_we     = 1'b1;
                ras_widx   = top + 1'b1;
                top_next   = top + 1'b1;
                count_next = ras_full ? ras_count : ras_count + 1'b1;
            end else if (pop) begin
                top_next   = top - 1'b1;
                count_next = ras_count - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            curPC      <= RESET_PC;
            pc_valid   <= 1'b0;
            misaligned <= 1'b0;
            ras_count  <= '0;
            top        <= '0;
        end else begin
            curPC      <= pc_next;
            pc_valid   <= 1'b1;
            misaligned <= mis_next;
            ras_count  <= count_next;
            top        <= top_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (ras_we)
            ras_mem[ras_widx] <= seq_pc;
    end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (default parameters: 32-bit, STEP 4, RAS depth 4).
module tb_pc_gen;
    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        stall, trap, redirect_valid, call, ret;
    logic [31:0] redirect_pc;
    logic [31:0] curPC;
    logic        pc_valid, misaligned, ras_full, ras_empty;
    logic [2:0]  ras_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pc_gen #(.WIDTH(32), .RESET_PC(32'h0), .TRAP_PC(32'h80), .STEP(4), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .stall(stall), .trap(trap),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .call(call), .ret(ret), .curPC(curPC), .pc_valid(pc_valid),
        .misaligned(misaligned), .ras_count(ras_count),
        .ras_full(ras_full), .ras_empty(ras_empty)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; trap = 0; redirect_valid = 0; call = 0; ret = 0; redirect_pc = '0;
    endtask

    task automatic jump(input logic [31:0] target);
        redirect_valid = 1; redirect_pc = target;
        step();
        redirect_valid = 0;
        check("jump", curPC, target);
    endtask

    initial begin
        logic [31:0] ret_pc  [5];
        logic [31:0] ret_cnt [5];
        ret_pc  = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h28};
        ret_cnt = '{3, 2, 1, 0, 0};

        clear_inputs();
        Reset_n = 0;
        #12;
        check("rst_pc", curPC, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_cnt", {29'b0, ras_count}, 32'd0);
        check("rst_empty", {31'b0, ras_empty}, 32'd1);
        check("rst_full", {31'b0, ras_full}, 32'd0);
        Reset_n = 1;

        step();
        check("first_valid", {31'b0, pc_valid}, 32'd1);
        check("first_pc", curPC, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", curPC, 32'(4 * i));
        end

        redirect_valid = 1; redirect_pc = 32'h106;
        step();
        redirect_valid = 0;
        check("redir_pc", curPC, 32'h104);
        check("redir_mis", {31'b0, misaligned}, 32'd1);
        step();
        check("redir_next", curPC, 32'h108);
        check("mis_pulse", {31'b0, misaligned}, 32'd0);

        jump(32'h10);
        for (int i = 0; i < 5; i++) begin
            call = 1;
            step();
            call = 0;
            check("call_pc", curPC, 32'(16 * (i + 1) + 4));
            check("call_cnt", {29'b0, ras_count}, (i < 4) ? 32'(i + 1) : 32'd4);
            check("call_full", {31'b0, ras_full}, (i >= 3) ? 32'd1 : 32'd0);
            jump(32'(16 * (i + 2)));
        end

        ret = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ret_pc", curPC, ret_pc[i]);
            check("ret_cnt", {29'b0, ras_count}, ret_cnt[i]);
        end
        ret = 0;

        call = 1;
        step();
        call = 0;
        check("push_a", curPC, 32'h2C);
        jump(32'h200);
        call = 1;
        step();
        call = 0;
        check("push_b", curPC, 32'h204);
        step();
        check("adv", curPC, 32'h208);
        check("cnt2", {29'b0, ras_count}, 32'd2);

        stall = 1; call = 1; ret = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", curPC, 32'h208);
            check("stall_cnt", {29'b0, ras_count}, 32'd2);
        end
        stall = 0; call = 0;
        step();
        ret = 0;
        check("unstall_pop", curPC, 32'h204);
        check("unstall_cnt", {29'b0, ras_count}, 32'd1);

        call = 1; ret = 1;
        step();
        check("swap_pc", curPC, 32'h2C);
        check("swap_cnt", {29'b0, ras_count}, 32'd1);
        ret = 0;
        step();
        call = 0;
        check("push_c", curPC, 32'h30);
        check("cnt_c", {29'b0, ras_count}, 32'd2);
        ret = 1;
        step();
        check("pop_c", curPC, 32'h30);
        step();
        ret = 0;
        check("pop_swapped", curPC, 32'h208);
        check("cnt_0", {29'b0, ras_count}, 32'd0);

        call = 1;
        step();
        step();
        call = 0;
        check("cnt_2b", {29'b0, ras_count}, 32'd2);
        check("pc_2b", curPC, 32'h210);

        trap = 1; redirect_valid = 1; redirect_pc = 32'h123; ret = 1;
        step();
        clear_inputs();
        check("trap_pc", curPC, 32'h80);
        check("trap_cnt", {29'b0, ras_count}, 32'd0);
        check("trap_mis", {31'b0, misaligned}, 32'd0);
        check("trap_empty", {31'b0, ras_empty}, 32'd1);

        call = 1; ret = 1;
        step();
        clear_inputs();
        check("empty_callret_pc", curPC, 32'h84);
        check("empty_callret_cnt", {29'b0, ras_count}, 32'd1);

        jump(32'hFFFF_FFFC);
        step();
        check("wrap", curPC, 32'h0);
        step();
        check("post_wrap", curPC, 32'h4);

        #2 Reset_n = 0;
        #1;
        check("async_pc", curPC, 32'h0);
        check("async_valid", {31'b0, pc_valid}, 32'd0);
        check("async_cnt", {29'b0, ras_count}, 32'd0);
        Reset_n = 1;
        step();
        check("rerel_valid", {31'b0, pc_valid}, 32'd1);
        check("rerel_pc", curPC, 32'h0);
        step();
        check("rerel_seq", curPC, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
